data_mem_responder: RTL and testbench

Memory-side responder for the load/store control signals. Accepts one request at a time (`mem_read` / `mem_write` with address and write data) through a valid/ready handshake. Services the request against an internal word array after a fixed, programmable wait, then returns a response (read data or write acknowledge) through a second valid/ready handshake. Sits between the control unit/datapath and data storage, so datapath timing is decoupled from memory latency.

---
 rtl/data_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder. Accepts one load/store request at a time over a
//   valid/ready handshake. After a fixed LATENCY wait it accesses an internal
//   word array and returns the result over a second valid/ready handshake.
//
// Parameters
//   DATA_W   data word width
//   ADDR_W   address width (array depth 2**ADDR_W)
//   LATENCY  wait cycles between accept and response (0..15)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (req_ready is registered)
//   mem_read, mem_write  op select (mem_write=1 -> store, else load)
//   addr, wdata          word address and store data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            load data (0 for store or error responses)
//   rsp_write            response acknowledges a store
//   rsp_err              illegal request flag
//
// Optional feature: define DATA_MEM_RESPONDER_ERR_EN to flag requests with
// both or neither of mem_read/mem_write as illegal. Such requests are timed
// normally, skip the array access and respond with rsp_err=1. Without the
// macro rsp_err is constant 0.
module data_mem_responder #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              rsp_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q, err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rsp_write_q, rsp_err_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Op decode of the live request inputs.
  logic dec_write, dec_err;
`ifdef DATA_MEM_RESPONDER_ERR_EN
  assign dec_err   = (mem_read == mem_write);
  assign dec_write = mem_write & ~dec_err;
`else
  logic unused_mem_read;
  assign unused_mem_read = mem_read;
  assign dec_err   = 1'b0;
  assign dec_write = mem_write;
`endif

  // req_ready_q is only ever high in IDLE, so it alone qualifies accept.
  logic accept, enter_rsp;
  assign accept = req_valid & req_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
        cnt_d   = LAT_M1;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_rsp = (state_q != S_RESP) && (state_d == S_RESP);

  // With LATENCY=0 the access happens on the accept edge itself, before the
  // request fields have been latched, so take them straight from the ports.
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_write, acc_err;
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_write = dec_write;
      acc_err   = dec_err;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_write = wr_q;
      acc_err   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == S_IDLE);
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wr_q    <= dec_write;
        err_q   <= dec_err;
      end
      if (enter_rsp) begin
        rdata_q     <= (acc_write || acc_err) ? '0 : mem[acc_addr];
        rsp_write_q <= acc_write;
        rsp_err_q   <= acc_err;
      end else if (state_q == S_RESP && rsp_ready) begin
        rdata_q     <= '0;
        rsp_write_q <= 1'b0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

  // Array is not reset; a store commits on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (enter_rsp && acc_write) mem[acc_addr] <= acc_wdata;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  // index 0: LATENCY=2 instance, index 1: LATENCY=0 instance
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid_s [2];
  logic       req_ready_s [2];
  logic       mem_read_s  [2];
  logic       mem_write_s [2];
  logic [3:0] addr_s      [2];
  logic [7:0] wdata_s     [2];
  logic       rsp_valid_s [2];
  logic       rsp_ready_s [2];
  logic [7:0] rsp_rdata_s [2];
  logic       rsp_write_s [2];
  logic       rsp_err_s   [2];

  int checks = 0;
  int fails  = 0;
  int lat;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
    .mem_read(mem_read_s[0]), .mem_write(mem_write_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
    .rsp_rdata(rsp_rdata_s[0]), .rsp_write(rsp_write_s[0]), .rsp_err(rsp_err_s[0])
  );

  data_mem_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
    .mem_read(mem_read_s[1]), .mem_write(mem_write_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
    .rsp_rdata(rsp_rdata_s[1]), .rsp_write(rsp_write_s[1]), .rsp_err(rsp_err_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge. Drives a request, waits for accept, then counts
  // negedges until rsp_valid is seen (1 = visible the cycle after accept).
  task automatic do_req(input int d, input bit wr, input bit rd,
                        input logic [3:0] a, input logic [7:0] wd, output int l);
    int n = 0;
    req_valid_s[d] = 1'b1; mem_write_s[d] = wr; mem_read_s[d] = rd;
    addr_s[d] = a; wdata_s[d] = wd;
    while (!req_ready_s[d] && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_s[d] = 1'b0;
    l = 1;
    while (!rsp_valid_s[d] && l < 40) begin @(negedge clk); l++; end
  endtask

  task automatic take(input int d, input string tag);
    rsp_ready_s[d] = 1'b1;
    @(negedge clk);
    rsp_ready_s[d] = 1'b0;
    chk({tag, "_vld_clr"}, 32'(rsp_valid_s[d]), 32'd0);
    chk({tag, "_rdata_clr"}, 32'(rsp_rdata_s[d]), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_s[0]), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid_s[0]), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata_s[0]), 32'd0);
    chk({tag, "_rsp_write"}, 32'(rsp_write_s[0]), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err_s[0]),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid_s[d] = 0; mem_read_s[d] = 0; mem_write_s[d] = 0;
      addr_s[d] = 0; wdata_s[d] = 0; rsp_ready_s[d] = 0;
    end
    // Reset state
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", 32'(req_ready_s[0]), 32'd0);
    @(negedge clk);
    chk("rdy_after_edge", 32'(req_ready_s[0]), 32'd1);

    // Store then load, LATENCY=2
    do_req(0, 1, 0, 4'd3, 8'hA5, lat);
    chk("st3_lat", lat, 3);
    chk("st3_write", 32'(rsp_write_s[0]), 32'd1);
    chk("st3_rdata", 32'(rsp_rdata_s[0]), 32'd0);
    chk("st3_err", 32'(rsp_err_s[0]), 32'd0);
    take(0, "st3");
    do_req(0, 0, 1, 4'd3, 8'h00, lat);
    chk("ld3_lat", lat, 3);
    chk("ld3_rdata", 32'(rsp_rdata_s[0]), 32'hA5);
    chk("ld3_write", 32'(rsp_write_s[0]), 32'd0);

    // Backpressure on the load response with a competing request present
    req_valid_s[0] = 1'b1; mem_write_s[0] = 1'b1; mem_read_s[0] = 1'b0;
    addr_s[0] = 4'd3; wdata_s[0] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_vld", 32'(rsp_valid_s[0]), 32'd1);
      chk("bp_rdata", 32'(rsp_rdata_s[0]), 32'hA5);
      chk("bp_rdy", 32'(req_ready_s[0]), 32'd0);
    end
    req_valid_s[0] = 1'b0;
    take(0, "bp");
    chk("bp_rdy_back", 32'(req_ready_s[0]), 32'd1);
    // The store of 0x5A offered during backpressure must not have landed
    do_req(0, 0, 1, 4'd3, 8'h00, lat);
    chk("bp_ld3_rdata", 32'(rsp_rdata_s[0]), 32'hA5);
    take(0, "bp_ld");

    // LATENCY=0 back-to-back with rsp_ready tied high
    rsp_ready_s[1] = 1'b1;
    do_req(1, 1, 0, 4'd0, 8'h11, lat);
    chk("l0_st_lat", lat, 1);
    chk("l0_st_write", 32'(rsp_write_s[1]), 32'd1);
    do_req(1, 0, 1, 4'd0, 8'h00, lat);
    chk("l0_ld_lat", lat, 1);
    chk("l0_ld_rdata", 32'(rsp_rdata_s[1]), 32'h11);
    @(negedge clk);
    chk("l0_vld_drop", 32'(rsp_valid_s[1]), 32'd0);
    rsp_ready_s[1] = 1'b0;

    // Reset while a store sits in WAIT
    do_req(0, 1, 0, 4'd5, 8'h00, lat);
    take(0, "st5_zero");
    req_valid_s[0] = 1'b1; mem_write_s[0] = 1'b1; mem_read_s[0] = 1'b0;
    addr_s[0] = 4'd5; wdata_s[0] = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    req_valid_s[0] = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero("rst_wait");
    @(negedge clk);
    chk_zero("rst_wait2");
    rst_n = 1'b1;
    @(negedge clk);
    do_req(0, 0, 1, 4'd5, 8'h00, lat);
    chk("ld5_lat", lat, 3);
    chk("ld5_rdata", 32'(rsp_rdata_s[0]), 32'h00);
    take(0, "ld5");

    // Both mem_read and mem_write high
    do_req(0, 1, 0, 4'd2, 8'h42, lat);
    take(0, "st2");
    do_req(0, 1, 1, 4'd2, 8'hFF, lat);
    chk("both_lat", lat, 3);
    chk("both_rdata", 32'(rsp_rdata_s[0]), 32'd0);
`ifdef DATA_MEM_RESPONDER_ERR_EN
    chk("both_err", 32'(rsp_err_s[0]), 32'd1);
    chk("both_write", 32'(rsp_write_s[0]), 32'd0);
`else
    chk("both_err", 32'(rsp_err_s[0]), 32'd0);
    chk("both_write", 32'(rsp_write_s[0]), 32'd1);
`endif
    take(0, "both");
    chk("both_err_clr", 32'(rsp_err_s[0]), 32'd0);
    do_req(0, 0, 1, 4'd2, 8'h00, lat);
`ifdef DATA_MEM_RESPONDER_ERR_EN
    chk("ld2_rdata", 32'(rsp_rdata_s[0]), 32'h42);
`else
    chk("ld2_rdata", 32'(rsp_rdata_s[0]), 32'hFF);
`endif
    take(0, "ld2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
